// File: rtl/cardinal_id_if.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_id_if
// Description : Fetch-to-decode handshake and the ID/EX bundle of the
//               Cardinal instruction-decode stage. The decoder takes the
//               slave side; fetch and execute together take the master side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cardinal_id_if;
  // Fetch side. Big-endian bit numbering: bit 0 is the MSB.
  logic        if_valid;
  logic [0:31] if_instr;
  logic        id_ready;

  // Execute side: registered ID/EX bundle
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_opcode;
  logic [1:0]  ex_ww;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_ra;
  logic [4:0]  ex_rb;
  logic [15:0] ex_imm;
  logic [7:0]  ex_wmask;
  logic [2:0]  ex_kind;
  logic        ex_rf_we;
  logic        ex_mc;
  logic        ex_illegal;

  modport master (
    output if_valid, if_instr, ex_ready,
    input  id_ready, ex_valid, ex_opcode, ex_ww, ex_rd, ex_ra, ex_rb,
           ex_imm, ex_wmask, ex_kind, ex_rf_we, ex_mc, ex_illegal
  );

  modport slave (
    input  if_valid, if_instr, ex_ready,
    output id_ready, ex_valid, ex_opcode, ex_ww, ex_rd, ex_ra, ex_rb,
           ex_imm, ex_wmask, ex_kind, ex_rf_we, ex_mc, ex_illegal
  );
endinterface
`default_nettype wire

// File: rtl/cardinal_id.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_id
// Description : Cardinal instruction-decode stage. Decodes R-type vector ALU,
//               load/store, branch and NOP formats into a registered ID/EX
//               bundle behind a valid/ready handshake. With the macro
//               CARDINAL_ID_MC_HOLD_EN defined, multi-cycle ALU functions
//               (func 14, 15, 18) hold the bundle for MC_LAT cycles before
//               it is presented as valid.
// Revision    : 1.0 - initial release
// ============================================================================
module cardinal_id #(
  parameter int MC_LAT = 16  // legal range 2..63
) (
  input  logic         clk,
  input  logic         rst_n,
  cardinal_id_if.slave bus
);

  localparam logic [5:0] c_OP_RTYPE = 6'b101010;
  localparam logic [5:0] c_OP_VLD   = 6'b100000;
  localparam logic [5:0] c_OP_VSD   = 6'b100001;
  localparam logic [5:0] c_OP_VBEZ  = 6'b100010;
  localparam logic [5:0] c_OP_VBNEZ = 6'b100011;
  localparam logic [5:0] c_OP_VNOP  = 6'b111100;

  localparam logic [2:0] c_KIND_ALU   = 3'd0;
  localparam logic [2:0] c_KIND_LOAD  = 3'd1;
  localparam logic [2:0] c_KIND_STORE = 3'd2;
  localparam logic [2:0] c_KIND_BEZ   = 3'd3;
  localparam logic [2:0] c_KIND_BNEZ  = 3'd4;
  localparam logic [2:0] c_KIND_NOP   = 3'd5;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t r_state;
  logic   r_valid;

  // Instruction fields
  logic [5:0]  w_prim;
  logic [5:0]  w_func;
  logic [4:0]  w_rd;
  logic [4:0]  w_ra;
  logic [4:0]  w_rb;
  logic [2:0]  w_ppp;
  logic [1:0]  w_wwf;
  logic [15:0] w_imm;

  assign w_prim = bus.if_instr[0:5];
  assign w_rd   = bus.if_instr[6:10];
  assign w_ra   = bus.if_instr[11:15];
  assign w_rb   = bus.if_instr[16:20];
  assign w_ppp  = bus.if_instr[21:23];
  assign w_wwf  = bus.if_instr[24:25];
  assign w_func = bus.if_instr[26:31];
  assign w_imm  = bus.if_instr[16:31];

  // Decoded control for the instruction currently offered by fetch
  logic [5:0] w_opcode;
  logic [1:0] w_ww;
  logic [7:0] w_wmask;
  logic [2:0] w_kind;
  logic       w_rf_we;
  logic       w_illegal;

  // Bundle registers
  logic [5:0]  r_opcode;
  logic [1:0]  r_ww;
  logic [4:0]  r_rd;
  logic [4:0]  r_ra;
  logic [4:0]  r_rb;
  logic [15:0] r_imm;
  logic [7:0]  r_wmask;
  logic [2:0]  r_kind;
  logic        r_rf_we;
  logic        r_illegal;

  logic w_id_ready;
  logic w_accept;

  // Reset forces id_ready low; in FULL a new instruction enters only as the old one retires
  assign w_id_ready = rst_n & ((r_state == S_EMPTY) | ((r_state == S_FULL) & bus.ex_ready));
  assign w_accept   = bus.if_valid & w_id_ready;

  // Primary-opcode decode; illegal encodings collapse to a non-writing NOP bundle
  always_comb begin
    w_opcode  = 6'd0;
    w_ww      = 2'd0;
    w_wmask   = 8'h00;
    w_kind    = c_KIND_NOP;
    w_rf_we   = 1'b0;
    w_illegal = 1'b0;
    case (w_prim)
      c_OP_RTYPE: begin
        if (w_func == 6'd0 || w_func > 6'd18 || w_ppp > 3'd4) begin
          w_illegal = 1'b1;
        end else begin
          w_kind   = c_KIND_ALU;
          w_opcode = w_func;
          w_ww     = w_wwf;
          w_rf_we  = 1'b1;
          case (w_ppp)
            3'd0:    w_wmask = 8'hFF;
            3'd1:    w_wmask = 8'hF0;
            3'd2:    w_wmask = 8'h0F;
            3'd3:    w_wmask = 8'hAA;
            default: w_wmask = 8'h55;
          endcase
        end
      end
      c_OP_VLD: begin
        w_kind  = c_KIND_LOAD;
        w_rf_we = 1'b1;
        w_wmask = 8'hFF;
      end
      c_OP_VSD: begin
        w_kind  = c_KIND_STORE;
        w_wmask = 8'hFF;
      end
      c_OP_VBEZ:  w_kind = c_KIND_BEZ;
      c_OP_VBNEZ: w_kind = c_KIND_BNEZ;
      c_OP_VNOP:  w_kind = c_KIND_NOP;
      default:    w_illegal = 1'b1;
    endcase
  end

`ifdef CARDINAL_ID_MC_HOLD_EN
  localparam logic [5:0] c_MC_LOAD = 6'(MC_LAT - 1);

  logic       r_mc;
  logic [5:0] r_cnt;
  logic       w_go_hold;

  // Only legal R-type vdivu/vmodu/vsqrtu need the settle hold
  assign w_go_hold = (w_kind == c_KIND_ALU) &&
                     (w_func == 6'd14 || w_func == 6'd15 || w_func == 6'd18);
`endif

  // Handshake sequencing: single pipeline slot plus the multi-cycle settle hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
`ifdef CARDINAL_ID_MC_HOLD_EN
      r_mc    <= 1'b0;
      r_cnt   <= 6'd0;
`endif
    end else begin
      case (r_state)
        S_EMPTY, S_FULL: begin
          if (w_accept) begin
`ifdef CARDINAL_ID_MC_HOLD_EN
            if (w_go_hold) begin
              r_state <= S_HOLD;
              r_valid <= 1'b0;
              r_mc    <= 1'b1;
              r_cnt   <= c_MC_LOAD;
            end else begin
              r_state <= S_FULL;
              r_valid <= 1'b1;
            end
`else
            r_state <= S_FULL;
            r_valid <= 1'b1;
`endif
          end else if (r_state == S_FULL && bus.ex_ready) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
          end
        end
`ifdef CARDINAL_ID_MC_HOLD_EN
        S_HOLD: begin
          if (r_cnt == 6'd0) begin
            r_state <= S_FULL;
            r_valid <= 1'b1;
            r_mc    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
`endif
        default: begin
          r_state <= S_EMPTY;
          r_valid <= 1'b0;
`ifdef CARDINAL_ID_MC_HOLD_EN
          r_mc    <= 1'b0;
`endif
        end
      endcase
    end
  end

  // Bundle loads only on accept, so it stays frozen under backpressure and during HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode  <= 6'd0;
      r_ww      <= 2'd0;
      r_rd      <= 5'd0;
      r_ra      <= 5'd0;
      r_rb      <= 5'd0;
      r_imm     <= 16'd0;
      r_wmask   <= 8'h00;
      r_kind    <= 3'd0;
      r_rf_we   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_opcode  <= w_opcode;
      r_ww      <= w_ww;
      r_rd      <= w_rd;
      r_ra      <= w_ra;
      r_rb      <= w_rb;
      r_imm     <= w_imm;
      r_wmask   <= w_wmask;
      r_kind    <= w_kind;
      r_rf_we   <= w_rf_we;
      r_illegal <= w_illegal;
    end
  end

  assign bus.id_ready   = w_id_ready;
  assign bus.ex_valid   = r_valid;
  assign bus.ex_opcode  = r_opcode;
  assign bus.ex_ww      = r_ww;
  assign bus.ex_rd      = r_rd;
  assign bus.ex_ra      = r_ra;
  assign bus.ex_rb      = r_rb;
  assign bus.ex_imm     = r_imm;
  assign bus.ex_wmask   = r_wmask;
  assign bus.ex_kind    = r_kind;
  assign bus.ex_rf_we   = r_rf_we;
  assign bus.ex_illegal = r_illegal;
`ifdef CARDINAL_ID_MC_HOLD_EN
  assign bus.ex_mc      = r_mc;
`else
  assign bus.ex_mc      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cardinal_id.sv
`default_nettype none
// ============================================================================
// Module      : tb_cardinal_id
// Description : Self-checking bench for cardinal_id. A reference decoder
//               pushes the expected bundle at every accept; each retire
//               (ex_valid & ex_ready) pops and compares. Directed checks
//               cover reset, backpressure, multi-cycle latency, and reset
//               during HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cardinal_id;

  localparam int MC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cardinal_id_if bus();

  cardinal_id #(.MC_LAT(MC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [5:0]  opcode;
    logic [1:0]  ww;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] imm;
    logic [7:0]  wmask;
    logic [2:0]  kind;
    logic        rf_we;
    logic        illegal;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t observed();
    return {bus.ex_opcode, bus.ex_ww, bus.ex_rd, bus.ex_ra, bus.ex_rb,
            bus.ex_imm, bus.ex_wmask, bus.ex_kind, bus.ex_rf_we, bus.ex_illegal};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic [2:0] ppp,
                                       input logic [1:0] ww, input logic [5:0] func);
    return {6'b101010, rd, ra, rb, ppp, ww, func};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] prim, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [15:0] imm);
    return {prim, rd, ra, imm};
  endfunction

  // Reference decoder written from the instruction format table
  function automatic exp_t model(input logic [31:0] ins);
    exp_t       e;
    logic [5:0] prim;
    logic [2:0] ppp;
    logic [5:0] func;
    prim = ins[31:26];
    ppp  = ins[10:8];
    func = ins[5:0];
    e        = '0;
    e.rd     = ins[25:21];
    e.ra     = ins[20:16];
    e.rb     = ins[15:11];
    e.imm    = ins[15:0];
    e.kind   = 3'd5;
    case (prim)
      6'b101010: begin
        if (func == 0 || func > 18 || ppp > 4) e.illegal = 1'b1;
        else begin
          e.kind   = 3'd0;
          e.opcode = func;
          e.ww     = ins[7:6];
          e.rf_we  = 1'b1;
          case (ppp)
            3'd0: e.wmask = 8'hFF;
            3'd1: e.wmask = 8'hF0;
            3'd2: e.wmask = 8'h0F;
            3'd3: e.wmask = 8'hAA;
            default: e.wmask = 8'h55;
          endcase
        end
      end
      6'b100000: begin e.kind = 3'd1; e.rf_we = 1'b1; e.wmask = 8'hFF; end
      6'b100001: begin e.kind = 3'd2; e.wmask = 8'hFF; end
      6'b100010: e.kind = 3'd3;
      6'b100011: e.kind = 3'd4;
      6'b111100: e.kind = 3'd5;
      default:   e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard: compare on retire, then record any new accept on the same edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ex_valid && bus.ex_ready) begin
        check("retire_expected", 64'(q.size() > 0), 64'd1);
        check("retire_mc", bus.ex_mc, 1'b0);
        if (q.size() > 0) check("bundle", observed(), q.pop_front());
      end
      if (bus.if_valid && bus.id_ready) q.push_back(model(bus.if_instr));
    end
  end

  // Offer an instruction and return just after the edge that accepts it
  task automatic send(input logic [31:0] instr);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (bus.id_ready) break;
      if (i >= 200) begin
        check("send_accept", bus.id_ready, 1'b1);
        break;
      end
      @(posedge clk); #1;
      if (rand_rdy) bus.ex_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    if (rand_rdy) bus.ex_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    bus.if_valid = 1'b0;
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.ex_valid && !bus.ex_mc) break;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  ppps [6];
    logic [31:0] ins;
    ppps = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.ex_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_id_ready", bus.id_ready, 1'b0);
    check("rst_ex_valid", bus.ex_valid, 1'b0);
    check("rst_ex_mc", bus.ex_mc, 1'b0);
    check("rst_bundle", observed(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_id_ready", bus.id_ready, 1'b1);

    // VAND: valid with the decoded bundle on the next cycle
    bus.ex_ready = 1'b1;
    send(mk_r(5'd3, 5'd1, 5'd2, 3'b000, 2'b01, 6'd1));
    bus.if_valid = 1'b0;
    check("vand_valid", bus.ex_valid, 1'b1);
    check("vand_opcode", bus.ex_opcode, 6'd1);
    check("vand_ww", bus.ex_ww, 2'b01);
    check("vand_rd", bus.ex_rd, 5'd3);
    check("vand_ra", bus.ex_ra, 5'd1);
    check("vand_rb", bus.ex_rb, 5'd2);
    check("vand_wmask", bus.ex_wmask, 8'hFF);
    check("vand_rf_we", bus.ex_rf_we, 1'b1);
    drain();

    // Backpressure: three adds, execute stalled for three cycles
    bus.ex_ready = 1'b0;
    send(mk_r(5'd4, 5'd5, 5'd6, 3'd0, 2'd2, 6'd3));
    bus.if_instr = mk_r(5'd7, 5'd8, 5'd9, 3'd0, 2'd2, 6'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_id_ready", bus.id_ready, 1'b0);
      check("bp_valid", bus.ex_valid, 1'b1);
      check("bp_hold_rd", bus.ex_rd, 5'd4);
    end
    @(posedge clk); #1;
    bus.ex_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", bus.id_ready, 1'b1);
    @(posedge clk); #1;
    check("bp_second_valid", bus.ex_valid, 1'b1);
    check("bp_second_rd", bus.ex_rd, 5'd7);
    send(mk_r(5'd10, 5'd8, 5'd9, 3'd0, 2'd2, 6'd3));
    drain();

    // VDIVU: settle hold, with a competing instruction offered throughout
    bus.ex_ready = 1'b1;
    send(mk_r(5'd10, 5'd11, 5'd12, 3'd0, 2'd3, 6'd14));
    bus.if_instr = mk_i(6'b111100, 5'd0, 5'd0, 16'd0);
`ifdef CARDINAL_ID_MC_HOLD_EN
    for (int k = 1; k <= MC; k++) begin
      check("mc_flag", bus.ex_mc, 1'b1);
      check("mc_valid", bus.ex_valid, 1'b0);
      check("mc_id_ready", bus.id_ready, 1'b0);
      @(posedge clk); #1;
    end
    check("mc_done_valid", bus.ex_valid, 1'b1);
    check("mc_done_flag", bus.ex_mc, 1'b0);
`else
    check("sc_div_valid", bus.ex_valid, 1'b1);
    check("sc_div_mc", bus.ex_mc, 1'b0);
`endif
    check("div_rd", bus.ex_rd, 5'd10);
    bus.if_valid = 1'b0;
    drain();

    // PPP sweep then the remaining formats and illegal encodings, back to back
    foreach (ppps[i]) send(mk_r(5'(i + 1), 5'd2, 5'd3, ppps[i], 2'd1, 6'd5));
    send(mk_i(6'b000000, 5'd1, 5'd2, 16'hABCD));
    send(mk_r(5'd1, 5'd2, 5'd3, 3'd0, 2'd0, 6'd19));
    send(mk_r(5'd1, 5'd2, 5'd3, 3'd0, 2'd0, 6'd0));
    send(mk_r(5'd9, 5'd2, 5'd3, 3'd1, 2'd2, 6'd18));
    send(mk_i(6'b100000, 5'd7, 5'd3, 16'h1234));
    send(mk_i(6'b100001, 5'd8, 5'd4, 16'h5678));
    send(mk_i(6'b100010, 5'd0, 5'd5, 16'h0010));
    send(mk_i(6'b100011, 5'd0, 5'd6, 16'hFFF0));
    send(mk_i(6'b111100, 5'd0, 5'd0, 16'd0));
    drain();

    // Random mix under random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1: ins = mk_r(5'($urandom), 5'($urandom), 5'($urandom),
                         3'($urandom_range(0, 7)), 2'($urandom), 6'($urandom_range(0, 20)));
        2: ins = mk_i(6'b100000, 5'($urandom), 5'($urandom), 16'($urandom));
        3: ins = mk_i(6'(6'h20 + $urandom_range(1, 3)), 5'($urandom), 5'($urandom), 16'($urandom));
        4: ins = mk_i(6'b111100, 5'($urandom), 5'($urandom), 16'($urandom));
        default: ins = $urandom;
      endcase
      send(ins);
    end
    rand_rdy = 1'b0;
    drain();

    // Reset pulsed in the second HOLD cycle
    send(mk_r(5'd1, 5'd2, 5'd3, 3'd0, 2'd0, 6'd18));
    bus.if_valid = 1'b0;
    @(posedge clk); #1;
`ifdef CARDINAL_ID_MC_HOLD_EN
    check("hold2_mc", bus.ex_mc, 1'b1);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_mc", bus.ex_mc, 1'b0);
    check("arst_valid", bus.ex_valid, 1'b0);
    check("arst_id_ready", bus.id_ready, 1'b0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst2_id_ready", bus.id_ready, 1'b1);
    check("rst2_bundle", observed(), 64'd0);
    send(mk_i(6'b100000, 5'd7, 5'd1, 16'h1234));
    bus.if_valid = 1'b0;
    check("vld_valid", bus.ex_valid, 1'b1);
    check("vld_kind", bus.ex_kind, 3'd1);
    check("vld_rd", bus.ex_rd, 5'd7);
    check("vld_imm", bus.ex_imm, 16'h1234);
    check("vld_rf_we", bus.ex_rf_we, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cardinal_id.md
# cardinal_id

Instruction-decode stage of the Cardinal processor. Accepts one 32-bit instruction per cycle from fetch over a valid/ready handshake and decodes R-type vector ALU, load/store, branch and NOP formats. Results go into a registered ID/EX bundle: ALU function code, `ww`, register addresses, byte write mask and control flags. This bundle drives the combinational vector ALU and the register-file write port. Multi-cycle ALU functions (vdivu, vmodu, vsqrtu) are held stable on the ALU inputs for a fixed settle time before the bundle is presented as valid.

## Interface
- `MC_LAT`, 16: hold cycles for multi-cycle functions; legal range 2..63.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_valid`  in  1  fetch presents an instruction.
- `if_instr`  in  [0:31]  instruction, big-endian bit numbering (bit 0 = MSB).
- `id_ready`  out  1  decoder can accept this cycle.
- `ex_valid`  out  1  bundle valid for execute.
- `ex_ready`  in  1  execute consumes the bundle.
- `ex_opcode`  out  [5:0]  ALU function code.
- `ex_ww`  out  [1:0]  lane width.
- `ex_rd`, `ex_ra`, `ex_rb`  out  [4:0] each  register addresses.
- `ex_imm`  out  [15:0]  `if_instr[16:31]`.
- `ex_wmask`  out  [7:0]  byte write enables; bit 7 = byte 0 (bits 0:7 of the 64-bit word).
- `ex_kind`  out  [2:0]  0 alu, 1 load, 2 store, 3 bez, 4 bnez, 5 nop.
- `ex_rf_we`  out  1  register-file write.
- `ex_mc`  out  1  multi-cycle hold in progress.
- `ex_illegal`  out  1  undecodable instruction.

## Operation
- Fields:
  - primary opcode = `[0:5]`
  - rD = `[6:10]`, rA = `[11:15]`, rB = `[16:20]`
  - PPP = `[21:23]`, WW = `[24:25]`, func = `[26:31]`
- Primary opcode decode:
  - 101010 (R-type): kind 0; `ex_opcode` = func; `ex_ww` = WW; `ex_rf_we` = 1.
  - 100000 VLD: kind 1; `ex_rf_we` = 1; `ex_wmask` = FF.
  - 100001 VSD: kind 2; `ex_wmask` = FF.
  - 100010 VBEZ: kind 3.
  - 100011 VBNEZ: kind 4.
  - 111100 VNOP: kind 5.
- For all non-R-type instructions: `ex_opcode` = 0, `ex_ww` = 0, `ex_rf_we` = 0 unless stated above.
- PPP → `ex_wmask` (R-type only): 000 FF, 001 F0, 010 0F, 011 AA (even bytes), 100 55 (odd bytes).
- Illegal cases: unknown primary opcode, R-type func 0 or >18, or R-type PPP 101–111.
  - Response: `ex_illegal` = 1, kind 5, `ex_rf_we` = 0, `ex_wmask` = 00, `ex_opcode` = 0.
  - Illegal instructions still flow through the handshake.
- Multi-cycle functions: R-type func 14, 15, 18.
- State machine:
  - EMPTY: `ex_valid` = 0, `id_ready` = 1. On accept: go to HOLD if multi-cycle, else FULL.
  - FULL: `ex_valid` = 1, `id_ready` = `ex_ready`.
    - `ex_ready` & `if_valid`: load new bundle, go to FULL or HOLD.
    - `ex_ready` & !`if_valid`: go to EMPTY.
    - Otherwise: hold the bundle.
  - HOLD: `ex_valid` = 0, `ex_mc` = 1, `id_ready` = 0, bundle frozen.
    - Counter loads MC_LAT-1 on entry and decrements each cycle.
    - When the counter reaches 0: go to FULL.
- Accept = `if_valid` & `id_ready`. The bundle register loads only on accept.

## Timing
- Reset (async assert, sync deassert at the design level):
  - State EMPTY; counter 0.
  - All `ex_*` outputs 0.
  - `id_ready` forced 0 while `rst_n` is low.
- Single-cycle instruction: accepted at edge N, `ex_valid` = 1 from cycle N+1.
- Multi-cycle instruction: `ex_mc` = 1 for exactly MC_LAT cycles (N+1 .. N+MC_LAT), then `ex_valid` = 1 at cycle N+MC_LAT+1.
- Throughput: one single-cycle instruction per clock while `ex_ready` = 1. No bubble on FULL→FULL.
- Bundle stability: bundle outputs change only on accept, so they stay stable while `ex_valid` & !`ex_ready`, and throughout HOLD.
- Reset mid-HOLD or mid-FULL: the instruction is dropped, no partial retire, and `ex_valid`/`ex_mc` fall immediately.
- `if_valid` is ignored when `id_ready` = 0.

## Configuration
- `CARDINAL_ID_MC_HOLD_EN`
  - Defined: HOLD state and counter present; func 14/15/18 sequenced as above.
  - Undefined: HOLD and counter are removed. All functions are single-cycle, and `ex_mc` is tied to 0.

## Test plan
- VAND, reset then issue: primary 101010, rD=3, rA=1, rB=2, PPP=000, WW=01, func=1, with `ex_ready` = 1.
  - Next cycle: `ex_valid` = 1, `ex_opcode` = 1, `ex_ww` = 01, `ex_rd` = 3, `ex_ra` = 1, `ex_rb` = 2, `ex_wmask` = FF, `ex_rf_we` = 1.
- Backpressure: three back-to-back adds with `ex_ready` = 0 for 3 cycles.
  - `id_ready` = 0 and the first bundle is held.
  - On release, the second instruction is accepted in the same cycle the first retires; in-order, none lost.
- VDIVU (func 14) with MC_LAT = 4, macro defined.
  - `ex_mc` = 1 for cycles N+1..N+4 with `ex_valid` = 0 and `id_ready` = 0; `ex_valid` = 1 at N+5.
  - Macro undefined: `ex_valid` = 1 at N+1.
- PPP sweep over 000–100 gives `ex_wmask` FF, F0, 0F, AA, 55.
  - PPP 110 → `ex_illegal` = 1, `ex_wmask` = 00.
- Primary 000000 → `ex_illegal` = 1, kind 5, `ex_rf_we` = 0.
  - R-type func 19 → illegal.
  - VLD rD=7, imm=0x1234 → kind 1, `ex_rd` = 7, `ex_imm` = 1234, `ex_rf_we` = 1.
- `rst_n` pulsed low in the second HOLD cycle.
  - `ex_mc` and `ex_valid` drop asynchronously.
  - After release: `id_ready` = 1 and the next instruction decodes normally.
